// File: rtl/usb_data_buffer.sv
// rtl/usb_data_buffer.sv - 64-byte circular FIFO shared by USB RX and AHB/TX paths
// Optional error flags (overflow/underflow) enabled with USB_DATA_BUFFER_ERR_FLAGS_EN.
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              clear,
  input  logic              store_rx_packet_data,
  input  logic [7:0]        rx_packet_data,
  input  logic              store_tx_data,
  input  logic [7:0]        tx_data,
  input  logic              get_rx_data,
  input  logic              get_tx_packet_data,
  output logic [7:0]        rx_data,
  output logic [7:0]        tx_packet_data,
`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   buffer_occupancy
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic            empty, full, wr_req, rd_req, wr_en, rd_en, do_flush;
  logic [7:0]      wr_byte;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign wr_req   = store_rx_packet_data | store_tx_data;
  assign rd_req   = get_rx_data | get_tx_packet_data;
  assign do_flush = flush | clear;
  // The RX byte wins when both writers collide in one cycle.
  assign wr_byte  = store_rx_packet_data ? rx_packet_data : tx_data;

  // Accept decisions and next pointer values; a read frees a slot so a full buffer can also take a write.
  always_comb begin
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (do_flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      rd_en = rd_req & ~empty;
      wr_en = wr_req & (~full | rd_en);
      if (rd_en) rptr_nxt = rptr + PTR_ONE;
      if (wr_en) wptr_nxt = wptr + PTR_ONE;
    end
  end

  // Pointer and registered occupancy; the extra pointer MSB makes the modulo difference reach 64.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr             <= '0;
      rptr             <= '0;
      buffer_occupancy <= '0;
    end else begin
      wptr             <= wptr_nxt;
      rptr             <= rptr_nxt;
      buffer_occupancy <= wptr_nxt - rptr_nxt;
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ADDR_W-1:0]] <= wr_byte;
  end

  // Registered head byte, steered to the AHB side when both consumers ask at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else if (rd_en) begin
      if (get_rx_data) rx_data        <= mem[rptr[ADDR_W-1:0]];
      else             tx_packet_data <= mem[rptr[ADDR_W-1:0]];
    end
  end

`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
  // Sticky drop/ignore indicators, cleared with the buffer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (do_flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if ((wr_req && !wr_en) || (store_rx_packet_data && store_tx_data)) overflow <= 1'b1;
      if (rd_req && empty && !wr_req) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb/tb_usb_data_buffer.sv - table-driven and scoreboard bench for usb_data_buffer
module tb_usb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst, flush, clear, store_rx_packet_data, store_tx_data;
  logic       get_rx_data, get_tx_packet_data;
  logic [7:0] rx_packet_data, tx_data, rx_data, tx_packet_data;
  logic [6:0] buffer_occupancy;
`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  usb_data_buffer dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .clear(clear),
    .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
    .store_tx_data(store_tx_data), .tx_data(tx_data),
    .get_rx_data(get_rx_data), .get_tx_packet_data(get_tx_packet_data),
    .rx_data(rx_data), .tx_packet_data(tx_packet_data),
`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .buffer_occupancy(buffer_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       srx;
    logic [7:0] rb;
    bit       stx;
    logic [7:0] txb;
    bit       grx, gtx, fl, cl;
    int       occ;
  } vec_t;

  typedef struct {
    bit       tgt;
    logic [7:0] data;
  } sb_t;

  logic [7:0] model[$];
  sb_t        sb[$];
  logic [7:0] exp_rx, exp_tx;
  int         checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic idle();
    store_rx_packet_data = 0; store_tx_data = 0; get_rx_data = 0;
    get_tx_packet_data = 0; flush = 0; clear = 0;
    rx_packet_data = 0; tx_data = 0;
  endtask

  // One clock with the given inputs; the model predicts and the outputs are checked after the edge.
  task automatic cycle(input bit srx, input logic [7:0] rb, input bit stx, input logic [7:0] txb,
                       input bit grx, input bit gtx, input bit fl, input bit cl, input int exp_occ);
    sb_t e;
    store_rx_packet_data = srx; rx_packet_data = rb;
    store_tx_data = stx; tx_data = txb;
    get_rx_data = grx; get_tx_packet_data = gtx;
    flush = fl; clear = cl;
    if (fl || cl) begin
      model.delete();
    end else begin
      if ((grx || gtx) && model.size() > 0) begin
        e.tgt  = grx ? 1'b0 : 1'b1;
        e.data = model.pop_front();
        sb.push_back(e);
      end
      if ((srx || stx) && model.size() < 64) model.push_back(srx ? rb : txb);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.tgt) exp_tx = e.data; else exp_rx = e.data;
    end
    chk("occupancy", int'(buffer_occupancy), model.size());
    chk("rx_data", int'(rx_data), int'(exp_rx));
    chk("tx_packet_data", int'(tx_packet_data), int'(exp_tx));
    if (exp_occ >= 0) chk("table_occupancy", int'(buffer_occupancy), exp_occ);
    idle();
  endtask

  task automatic push(input logic [7:0] b);
    cycle(1, b, 0, 8'h00, 0, 0, 0, 0, -1);
  endtask

  task automatic pop_rx();
    cycle(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, -1);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{1, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 1};
    vt[1] = '{1, 8'h3C, 0, 8'h00, 0, 0, 0, 0, 2};
    vt[2] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1};
    vt[3] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0};
    vt[4] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0};
    vt[5] = '{0, 8'h00, 1, 8'h11, 0, 1, 0, 0, 1};
    vt[6] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0};
    vt[7] = '{1, 8'h55, 1, 8'h66, 0, 0, 0, 0, 1};
    vt[8] = '{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0};
    vt[9] = '{0, 8'h00, 1, 8'h22, 0, 0, 0, 1, 0};

    idle();
    exp_rx = 0; exp_tx = 0;
    n_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_occupancy", int'(buffer_occupancy), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_tx_packet_data", int'(tx_packet_data), 0);
    n_rst = 1;

    for (int i = 0; i < 10; i++)
      cycle(vt[i].srx, vt[i].rb, vt[i].stx, vt[i].txb, vt[i].grx, vt[i].gtx, vt[i].fl, vt[i].cl, vt[i].occ);

    // Fill to full, overflow byte dropped, drain in order.
    for (int i = 0; i < 64; i++) push(8'(i));
    cycle(1, 8'hFF, 0, 8'h00, 0, 0, 0, 0, 64);
    for (int i = 0; i < 64; i++) pop_rx();
    chk("drained_last", int'(rx_data), 8'h3F);

    // Full with simultaneous read and write, then drain across the wrap.
    for (int i = 0; i < 64; i++) push(8'(8'h80 + i));
    cycle(1, 8'h77, 0, 8'h00, 0, 1, 0, 0, 64);
    for (int i = 0; i < 64; i++) pop_rx();
    chk("wrap_last", int'(rx_data), 8'h77);

    // Flush at occupancy 10 discards the same-cycle write; next read is ignored.
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    cycle(1, 8'hEE, 0, 8'h00, 0, 0, 1, 0, 0);
    cycle(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0);

    // Asynchronous reset mid-fill, then normal resumption.
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    #3;
    n_rst = 0;
    #1;
    chk("async_occupancy", int'(buffer_occupancy), 0);
    chk("async_rx_data", int'(rx_data), 0);
    chk("async_tx_packet_data", int'(tx_packet_data), 0);
    model.delete(); sb.delete();
    exp_rx = 0; exp_tx = 0;
    @(posedge clk);
    #1;
    n_rst = 1;
    push(8'h5A);
    push(8'h6B);
    cycle(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1);
    pop_rx();
    chk("resume_rx", int'(rx_data), 8'h6B);
    chk("resume_tx", int'(tx_packet_data), 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
